text_shadow_vram: RTL and testbench
===================================

TEXT_SHADOW_VRAM -- requirements
Module: text_shadow_vram

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of posted CPU write entries (power of two, 2..8).
REQ-002 Parameter TEXT_BANK, default 7'h00, value cpu_addr[22:16] must match for a write to be captured.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  23  CPU write byte address.
REQ-006 cpu_din  input  8  CPU write data.
REQ-007 cpu_we  input  1  CPU write strobe, one write per high cycle.
REQ-008 cpu_stall  output  1  write FIFO full; CPU holds its write.
REQ-009 video_rd  input  1  video fetch strobe (driven from ce_pix).
REQ-010 video_addr  input  23  video fetch address, text page 1 = 23'h000400..23'h0007FF.
REQ-011 video_data  output  8  fetched character code, registered.
REQ-012 fifo_level  output  4  entries currently held, 0..FIFO_DEPTH.
REQ-013 overflow  output  1  sticky flag: a captured write was dropped.

Function
REQ-014 Block SHALL hold a 1024x8 text page RAM, index = address[9:0] of an in-window address.
REQ-015 A write SHALL be captured when cpu_we=1, cpu_addr[22:16]=TEXT_BANK and cpu_addr[15:10]=6'b000001; all other writes are ignored.
REQ-016 A captured write SHALL be pushed as {index, data} when fifo_level<FIFO_DEPTH, or when fifo_level=FIFO_DEPTH and a pop occurs the same cycle.
REQ-017 A captured write arriving with no free slot SHALL be dropped and SHALL set overflow; FIFO contents are unchanged.
REQ-018 cpu_stall SHALL be combinational: 1 exactly when fifo_level=FIFO_DEPTH.
REQ-019 Video reads SHALL have absolute priority over RAM writes: in a cycle with video_rd=1 no pop occurs.
REQ-020 In a cycle with video_rd=0 and fifo_level>0, the oldest entry SHALL be popped and written to RAM in that cycle.
REQ-021 On video_rd=1, video_data SHALL update on the next rising edge (1-cycle latency) with the byte at video_addr.
REQ-022 Read forwarding: if any FIFO entry (including one pushed in the same cycle) matches the read index, the newest matching entry's data SHALL be returned instead of RAM.
REQ-023 A video_addr outside the text window SHALL return 8'hA0 (inverse space).
REQ-024 With video_rd=0, video_data SHALL hold its last value.
REQ-025 fifo_level SHALL be incremented on push only, decremented on pop only, and unchanged on simultaneous push and pop.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order of RAM writes SHALL equal capture order.
REQ-027 overflow SHALL clear only on reset.

Reset
REQ-028 Reset SHALL force video_data=8'h00, fifo_level=0, overflow=0, pointers=0, cpu_stall=0; in-flight entries are discarded.
REQ-029 RAM contents SHALL NOT be reset and SHALL retain pre-reset data.
REQ-030 Reset asserted mid-drain SHALL abort the pending pop; no RAM write occurs in the reset cycle.

Structure
REQ-031 Package vram_pkg SHALL hold TEXT_BASE (23'h000400), TEXT_WORDS (1024), FILL_CHAR (8'hA0) and the FIFO entry type {index[9:0], data[7:0]}.
REQ-032 The posted-write FIFO SHALL be one sub-module, wr_fifo, exposing push/pop/level and all entries for forwarding compare.
REQ-033 RAM SHALL be inferred as single-port synchronous RAM with one access per cycle.

Verification
REQ-034 Write 8'hC1 to 23'h000400, video_rd=0 two cycles, then read 23'h000400 -> video_data=8'hC1 one cycle after strobe.
REQ-035 video_rd held 1 continuously, five writes to 23'h000410..414 -> four accepted, cpu_stall=1 at level 4, fifth dropped, overflow=1; release video_rd -> RAM drained in order over 4 cycles.
REQ-036 Write 8'h55 then 8'h66 to 23'h0007FF with video_rd=1, read 23'h0007FF -> video_data=8'h66 (newest forward).
REQ-037 Write to 23'h010400 and 23'h000800 -> fifo_level stays 0; read 23'h000300 -> video_data=8'hA0.
REQ-038 Level 4, video_rd=0, new captured write same cycle -> accepted, fifo_level stays 4, overflow stays 0.
REQ-039 Reset asserted with level 3 -> level 0, overflow 0, video_data 0; previously drained RAM bytes still readable.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and types for the text-page shadow VRAM
package vram_pkg;

    localparam logic [22:0] TEXT_BASE  = 23'h000400;
    localparam int          TEXT_WORDS = 1024;
    localparam logic [7:0]  FILL_CHAR  = 8'hA0;

    // One posted CPU write: RAM index and the byte to store there.
    typedef struct packed {
        logic [9:0] index;
        logic [7:0] data;
    } fifo_entry_t;

    // Source that drives video_data after a fetch.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_FWD  = 2'd2,
        SEL_FILL = 2'd3
    } rd_sel_e;

    // True when a video address lies inside text page 1 (0x400..0x7FF).
    function automatic logic in_text_window(input logic [22:0] addr);
        return addr[22:10] == TEXT_BASE[22:10];
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// rtl/wr_fifo.sv - posted-write FIFO with age-ordered view of every entry
module wr_fifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t pop_entry,
    output logic [3:0]  level,
    output fifo_entry_t age_entry [DEPTH],
    output logic [DEPTH-1:0] age_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage needs no reset: the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
        end
    end

    assign pop_entry = mem[rd_ptr];

    // Rotate storage so slot 0 is the oldest entry; higher slots are newer.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entry[k] = mem[rd_ptr + PTR_W'(k)];
            age_valid[k] = (4'(k) < level);
        end
    end

endmodule

// File: rtl/text_shadow_vram.sv
// rtl/text_shadow_vram.sv - shadow copy of text page 1 with posted CPU writes and video fetch
module text_shadow_vram
    import vram_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [6:0] TEXT_BANK  = 7'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    output logic        cpu_stall,
    input  logic        video_rd,
    input  logic [22:0] video_addr,
    output logic [7:0]  video_data,
    output logic [3:0]  fifo_level,
    output logic        overflow
);

    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    logic        captured;
    logic        full;
    logic        push;
    logic        pop;
    fifo_entry_t push_entry;
    fifo_entry_t pop_entry;
    fifo_entry_t age_entry [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] age_valid;

    logic [9:0]  rd_idx;
    logic        rd_in_window;
    logic        fwd_hit;
    logic [7:0]  fwd_data;

    logic [7:0]  ram [TEXT_WORDS];
    logic [9:0]  ram_addr;
    logic [7:0]  ram_q;
    rd_sel_e     rd_sel;
    logic [7:0]  fwd_q;

    assign captured   = cpu_we && (cpu_addr[22:16] == TEXT_BANK) && (cpu_addr[15:10] == 6'b000001);
    assign full       = (fifo_level == DEPTH_L);
    assign cpu_stall  = full;
    // Video fetches own the RAM port; draining only happens on idle video cycles.
    assign pop        = !video_rd && (fifo_level != 4'd0) && !reset;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push       = captured && (!full || pop);
    assign push_entry = '{index: cpu_addr[9:0], data: cpu_din};

    assign rd_idx       = video_addr[9:0];
    assign rd_in_window = in_text_window(video_addr);

    wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .pop_entry  (pop_entry),
        .level      (fifo_level),
        .age_entry  (age_entry),
        .age_valid  (age_valid)
    );

    // Newest pending write to the fetched index wins; a same-cycle push is newest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 8'h00;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (age_valid[k] && (age_entry[k].index == rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = age_entry[k].data;
            end
        end
        if (push && (push_entry.index == rd_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = push_entry.data;
        end
    end

    assign ram_addr = video_rd ? rd_idx : pop_entry.index;

    // Single-port RAM: either the drain write or the video read, never both.
    always_ff @(posedge clk) begin
        if (pop) begin
            ram[ram_addr] <= pop_entry.data;
        end else if (video_rd) begin
            ram_q <= ram[ram_addr];
        end
    end

    // Capture which source answers the fetch; all sources hold while video_rd is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_sel <= SEL_ZERO;
            fwd_q  <= 8'h00;
        end else if (video_rd) begin
            if (!rd_in_window) begin
                rd_sel <= SEL_FILL;
            end else if (fwd_hit) begin
                rd_sel <= SEL_FWD;
                fwd_q  <= fwd_data;
            end else begin
                rd_sel <= SEL_RAM;
            end
        end
    end

    // Dropped writes latch until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (captured && !push) begin
            overflow <= 1'b1;
        end
    end

    // Output select driven only by flops, so video_data changes only on a clock edge.
    always_comb begin
        case (rd_sel)
            SEL_RAM:  video_data = ram_q;
            SEL_FWD:  video_data = fwd_q;
            SEL_FILL: video_data = FILL_CHAR;
            default:  video_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_text_shadow_vram.sv
// tb/tb_text_shadow_vram.sv - scoreboard bench for text_shadow_vram
module tb_text_shadow_vram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [22:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_stall;
    logic        video_rd = 1'b0;
    logic [22:0] video_addr = '0;
    logic [7:0]  video_data;
    logic [3:0]  fifo_level;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    text_shadow_vram #(
        .FIFO_DEPTH(4),
        .TEXT_BANK (7'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_we     (cpu_we),
        .cpu_stall  (cpu_stall),
        .video_rd   (video_rd),
        .video_addr (video_addr),
        .video_data (video_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cycle(input logic we, input logic [22:0] wa, input logic [7:0] wd,
                         input logic rd, input logic [22:0] ra, input logic [7:0] ex);
        cpu_we     = we;
        cpu_addr   = wa;
        cpu_din    = wd;
        video_rd   = rd;
        video_addr = ra;
        if (rd) exp_q.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 23'h0, 8'h00, 1'b0, 23'h0, 8'h00);
    endtask

    // Monitor: every fetch strobe seen at an edge is answered by the next half-cycle.
    initial begin : monitor
        logic seen;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            seen = video_rd && !reset;
            @(negedge clk);
            if (seen) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_empty: got %h expected none", video_data);
                end else begin
                    e = exp_q.pop_front();
                    if (video_data !== e) begin
                        fails++;
                        $display("FAIL video_data: got %h expected %h", video_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_video_data", video_data, 8'h00);
        check("rst_level", {4'h0, fifo_level}, 8'h00);
        check("rst_overflow", {7'h0, overflow}, 8'h00);
        check("rst_stall", {7'h0, cpu_stall}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();

        // Basic write, drain, read back
        cycle(1'b1, 23'h000400, 8'hC1, 1'b0, 23'h0, 8'h00);
        check("w1_level", {4'h0, fifo_level}, 8'h01);
        idle();
        check("w1_drained", {4'h0, fifo_level}, 8'h00);
        idle();
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000400, 8'hC1);
        idle();

        // Newest-entry forwarding, including same-cycle push
        cycle(1'b1, 23'h0007FF, 8'h55, 1'b1, 23'h0007FF, 8'h55);
        cycle(1'b1, 23'h0007FF, 8'h66, 1'b1, 23'h0007FF, 8'h66);
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h0007FF, 8'h66);
        check("fwd_level", {4'h0, fifo_level}, 8'h02);
        idle();
        idle();
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h0007FF, 8'h66);
        idle();

        // Out-of-window writes and reads
        cycle(1'b1, 23'h010400, 8'h77, 1'b0, 23'h0, 8'h00);
        check("bank_ignored", {4'h0, fifo_level}, 8'h00);
        cycle(1'b1, 23'h000800, 8'h78, 1'b0, 23'h0, 8'h00);
        check("page_ignored", {4'h0, fifo_level}, 8'h00);
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000300, 8'hA0);
        idle();

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 23'h000500 + 23'(i), 8'h20 + 8'(i), 1'b1, 23'h000300, 8'hA0);
        check("full_level", {4'h0, fifo_level}, 8'h04);
        check("full_stall", {7'h0, cpu_stall}, 8'h01);
        cycle(1'b1, 23'h000504, 8'h24, 1'b0, 23'h0, 8'h00);
        check("pushpop_level", {4'h0, fifo_level}, 8'h04);
        check("pushpop_overflow", {7'h0, overflow}, 8'h00);
        for (int i = 0; i < 4; i++) idle();
        check("pushpop_drained", {4'h0, fifo_level}, 8'h00);
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000500, 8'h20);
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000504, 8'h24);
        idle();

        // Overflow under continuous video reads, then ordered drain
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 23'h000410 + 23'(i), 8'h10 + 8'(i), 1'b1, 23'h000300, 8'hA0);
            check("ovf_level", {4'h0, fifo_level}, (i < 4) ? 8'(i + 1) : 8'h04);
            check("ovf_stall", {7'h0, cpu_stall}, (i >= 3) ? 8'h01 : 8'h00);
        end
        check("ovf_flag", {7'h0, overflow}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("drain_level", {4'h0, fifo_level}, 8'(3 - i));
        end
        check("ovf_sticky", {7'h0, overflow}, 8'h01);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000410 + 23'(i), 8'h10 + 8'(i));
        idle();

        // Reset with pending entries
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 23'h000600 + 23'(i), 8'h30 + 8'(i), 1'b1, 23'h000300, 8'hA0);
        check("pre_rst_level", {4'h0, fifo_level}, 8'h03);
        cpu_we = 1'b0;
        video_rd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_level", {4'h0, fifo_level}, 8'h00);
        check("mid_rst_overflow", {7'h0, overflow}, 8'h00);
        check("mid_rst_video", video_data, 8'h00);
        check("mid_rst_stall", {7'h0, cpu_stall}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000400, 8'hC1);
        cycle(1'b0, 23'h0, 8'h00, 1'b1, 23'h000413, 8'h13);
        idle();
        idle();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
